pulse_cmd_queue: RTL



---
 rtl/pulse_cmd_queue.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/pulse_cmd_queue.sv
// pulse_cmd_queue
// ---------------
// Buffers pulse commands {s, h} between a host and the triangular-pulse
// generator. Commands arrive over a 4-phase dav_/rfd handshake where this block
// is the consumer. They are held in a DEPTH-entry FIFO and replayed over a
// second 4-phase handshake where this block is the producer. Commands with
// h == 0 are discarded and counted in a saturating counter.
//
// Ports:
//   clock     in   system clock, all logic on posedge
//   reset_    in   synchronous active-low reset
//   in_s      in   host command sign (0 = positive pulse, 1 = negative pulse)
//   in_h      in   host command height in steps
//   in_dav_   in   host data valid, active low
//   in_rfd    out  ready for host data
//   s         out  sign to the pulse generator
//   h         out  height to the pulse generator
//   dav_      out  data valid to the pulse generator, active low
//   rfd       in   ready-for-data from the pulse generator
//   count     out  current FIFO occupancy, 0..DEPTH
//   drop_cnt  out  number of h == 0 commands discarded, saturates at 8'hFF

module pulse_cmd_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clock,
    input  logic          reset_,
    input  logic          in_s,
    input  logic [6:0]    in_h,
    input  logic          in_dav_,
    output logic          in_rfd,
    output logic          s,
    output logic [6:0]    h,
    output logic          dav_,
    input  logic          rfd,
    output logic [AW:0]   count,
    output logic [7:0]    drop_cnt
);

    localparam logic [AW:0] Full = (AW + 1)'(DEPTH);

    typedef enum logic {
        StAcc,
        StWaitHi
    } in_state_e;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StWaitAck
    } out_state_e;

    in_state_e    in_state_q, in_state_d;
    out_state_e   out_state_q, out_state_d;

    logic [7:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]  count_q, count_d;
    logic [7:0]   drop_cnt_q, drop_cnt_d;
    logic         s_q, s_d;
    logic [6:0]   h_q, h_d;

    logic         push;
    logic         drop;
    logic         load;
    logic         pop;

    // ------------------------------------------------------------------
    // Handshake events. Kept apart from the next-state logic so that the
    // WAIT_HI exit test can look at the post-pop occupancy without a
    // combinational feedback through the same process.
    // ------------------------------------------------------------------
    always_comb begin
        push = 1'b0;
        drop = 1'b0;
        if (in_state_q == StAcc && !in_dav_) begin
            if (in_h != 7'd0) begin
                push = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    always_comb begin
        load = (out_state_q == StIdle) && (count_q != '0) && rfd;
        pop  = (out_state_q == StWaitAck) && !rfd;
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping. Pointers wrap naturally because DEPTH == 2**AW.
    // A push is only possible from StAcc, which is only entered with room
    // to spare, so no overflow guard is needed here.
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Output data is captured from the FIFO head on load and then held until
    // the next load, so it stays stable across the whole dav_ low phase.
    always_comb begin
        s_d = s_q;
        h_d = h_q;
        if (load) begin
            s_d = mem_q[rd_ptr_q][7];
            h_d = mem_q[rd_ptr_q][6:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
            s_q        <= 1'b0;
            h_q        <= 7'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
            s_q        <= s_d;
            h_q        <= h_d;
        end
    end

    // Storage has no reset; occupancy and pointers alone define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_s, in_h};
        end
    end

    // ------------------------------------------------------------------
    // Input-side FSM (host consumer)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_) begin
            in_state_q <= StAcc;
        end else begin
            in_state_q <= in_state_d;
        end
    end

    always_comb begin
        in_state_d = in_state_q;
        unique case (in_state_q)
            StAcc: begin
                if (!in_dav_) begin
                    in_state_d = StWaitHi;
                end
            end
            StWaitHi: begin
                // Re-arm only once the host has released dav_ and there is
                // room after any pop completing on this same edge.
                if (in_dav_ && count_d != Full) begin
                    in_state_d = StAcc;
                end
            end
            default: in_state_d = StAcc;
        endcase
    end

    always_comb begin
        in_rfd = (in_state_q == StAcc);
    end

    // ------------------------------------------------------------------
    // Output-side FSM (generator producer)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_) begin
            out_state_q <= StIdle;
        end else begin
            out_state_q <= out_state_d;
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        unique case (out_state_q)
            StIdle: begin
                if (load) begin
                    out_state_d = StSetup;
                end
            end
            // One cycle of setup so s/h lead the falling dav_ by a clock.
            StSetup: begin
                out_state_d = StWaitAck;
            end
            StWaitAck: begin
                if (pop) begin
                    out_state_d = StIdle;
                end
            end
            default: out_state_d = StIdle;
        endcase
    end

    always_comb begin
        dav_ = (out_state_q != StWaitAck);
    end

    always_comb begin
        s        = s_q;
        h        = h_q;
        count    = count_q;
        drop_cnt = drop_cnt_q;
    end

endmodule
